// File: rtl/neonfox_pkg.sv
// Shared types and constants for the neonfox fetch path.
package neonfox_pkg;

  // Branch condition selector encodings ({H_en,L_en}).
  localparam logic [1:0] COND_ALWAYS = 2'b00;
  localparam logic [1:0] COND_N      = 2'b01;
  localparam logic [1:0] COND_Z      = 2'b10;
  localparam logic [1:0] COND_P      = 2'b11;

  // Program-counter / program-address type.
  typedef logic [15:0] pc_t;

  // Default return-address stack depth.
  localparam int RAS_DEPTH_DEF = 16;

  // Sign-extend a 10-bit branch offset to a full program address.
  function automatic pc_t sext_ifield(input logic [9:0] f);
    return {{6{f[9]}}, f};
  endfunction

endpackage

// File: rtl/fetch_unit_ras_stack.sv
// Circular return-address stack. A push at full depth overwrites the oldest
// entry; a pop when empty reuses the wrapped entry. Both set a sticky error.
module ras_stack
  import neonfox_pkg::*;
#(
  parameter int DEPTH = RAS_DEPTH_DEF
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  pc_t                        push_data,
  output pc_t                        top,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       err
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  logic [PTR_W-1:0] top_idx;
  pc_t              mem_q [DEPTH];

  assign top_idx = ptr_q - PTR_W'(1);
  assign top     = mem_q[top_idx];
  assign count   = cnt_q;
  assign err     = err_q;

  // Next pointer, occupancy and sticky error; push wins if both are requested.
  always_comb begin
    ptr_d = ptr_q;
    cnt_d = cnt_q;
    err_d = err_q;
    if (push) begin
      ptr_d = ptr_q + PTR_W'(1);
      if (cnt_q == CNT_W'(DEPTH)) begin
        err_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else if (pop) begin
      ptr_d = top_idx;
      if (cnt_q == '0) begin
        err_d = 1'b1;
      end else begin
        cnt_d = cnt_q - CNT_W'(1);
      end
    end
  end

  // Control state of the stack, cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= '0;
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  // Entry storage; contents are meaningless until written, so no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[ptr_q] <= push_data;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch / program counter: sequential fetch, redirect resolution
// for jump/call/return/branch, in-flight address tracking and flush control.
module fetch_unit
  import neonfox_pkg::*;
#(
  parameter pc_t RESET_VECTOR = 16'h0000,
  parameter int  RAS_DEPTH    = RAS_DEPTH_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        hazard,
  input  logic        p_cache_miss,
  input  logic        pc_jmp,
  input  logic        pc_call,
  input  logic        pc_ret,
  input  logic        pc_brx,
  input  logic        pc_brxt,
  input  logic [1:0]  cond_sel,
  input  logic        long_en,
  input  logic [9:0]  I_field,
  input  logic [15:0] aux_target,
  input  logic        status_n,
  input  logic        status_z,
  input  logic        status_p,
  output logic [15:0] prg_address,
  output logic [15:0] link_addr,
  output logic        jmp_rst,
  output logic        brx_rst,
  output logic        flush,
  output logic        ras_err
);

  localparam int RAS_CNT_W = $clog2(RAS_DEPTH) + 1;

  pc_t  prg_q, prg_d;
  pc_t  a_mem_q, a_mem_d;
  pc_t  a_ir_q, a_ir_d;
  pc_t  pc_exec_q, pc_exec_d;
  logic redirect_d1_q, redirect_d1_d;

  logic advance, accept, flag, taken;
  logic do_ret, do_call, do_jmp, brx_sel, redirect;
  pc_t  target, ras_top;
  logic [RAS_CNT_W-1:0] ras_count;

  // Requests are only honoured on a moving pipeline, outside reset, and not
  // in the cycle after a redirect (that request belongs to the wrong path).
  assign advance = ~hazard & ~p_cache_miss;
  assign accept  = advance & ~redirect_d1_q & ~rst;

  // Fixed priority: ret > call > jmp > brx.
  assign do_ret   = accept & pc_ret;
  assign do_call  = accept & pc_call & ~pc_ret;
  assign do_jmp   = accept & pc_jmp & ~pc_ret & ~pc_call;
  assign brx_sel  = accept & pc_brx & ~(pc_ret | pc_call | pc_jmp);
  assign redirect = do_ret | do_call | do_jmp | (brx_sel & taken);

  assign jmp_rst     = do_call | do_jmp;
  assign brx_rst     = brx_sel;
  assign flush       = redirect | redirect_d1_q;
  assign link_addr   = pc_exec_q + 16'd1;
  assign prg_address = prg_q;

  // Branch condition evaluation from the selected ALU flag.
  always_comb begin
    flag = 1'b0;
    unique case (cond_sel)
      COND_N:  flag = status_n;
      COND_Z:  flag = status_z;
      COND_P:  flag = status_p;
      default: flag = 1'b0;
    endcase
    taken = (cond_sel == COND_ALWAYS) | (flag ^ pc_brxt);
  end

  // Redirect target mux following the request priority.
  always_comb begin
    target = pc_exec_q + sext_ifield(I_field);
    if (do_ret) begin
      target = ras_top;
    end else if (do_call | do_jmp) begin
      target = long_en ? aux_target : {pc_exec_q[15:10], I_field};
    end
  end

  // Next fetch address and address pipeline; a redirect freezes the
  // pipeline for one cycle while flush kills the wrong-path slots.
  always_comb begin
    prg_d         = prg_q;
    a_mem_d       = a_mem_q;
    a_ir_d        = a_ir_q;
    pc_exec_d     = pc_exec_q;
    redirect_d1_d = redirect_d1_q;
    if (advance) begin
      redirect_d1_d = redirect;
      if (redirect) begin
        prg_d = target;
      end else begin
        prg_d     = prg_q + 16'd1;
        a_mem_d   = prg_q;
        a_ir_d    = a_mem_q;
        pc_exec_d = a_ir_q;
      end
    end
  end

  // Fetch state registers with asynchronous reset to the reset vector.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prg_q         <= RESET_VECTOR;
      a_mem_q       <= RESET_VECTOR;
      a_ir_q        <= RESET_VECTOR;
      pc_exec_q     <= RESET_VECTOR;
      redirect_d1_q <= 1'b0;
    end else begin
      prg_q         <= prg_d;
      a_mem_q       <= a_mem_d;
      a_ir_q        <= a_ir_d;
      pc_exec_q     <= pc_exec_d;
      redirect_d1_q <= redirect_d1_d;
    end
  end

  // Occupancy can never exceed the stack depth.
  always_comb begin
    assert (ras_count <= RAS_CNT_W'(RAS_DEPTH));
  end

  ras_stack #(
    .DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk       (clk),
    .rst       (rst),
    .push      (do_call),
    .pop       (do_ret),
    .push_data (link_addr),
    .top       (ras_top),
    .count     (ras_count),
    .err       (ras_err)
  );

endmodule
